iq_sample_packer: RTL and testbench
===================================

Name: iq_sample_packer

Overview:
- Packs a stream of 32-bit IQ samples (16-bit I in [31:16], 16-bit Q in [15:0]) into OUT_WIDTH-bit words.
- Each component is reduced to BITS bits.
- Sits after the demodulator and before packetisation. It replaces the fixed 4-into-1 compressor.
- Width, bit depth and lanes per word are parametrised; it adds partial-word flush on tlast, a lane count, and registered backpressure-safe output.

Parameters:
OUT_WIDTH, 32, output word width; must be a multiple of 2*BITS
BITS, 4, retained bits per I/Q component, legal range 1..16
LANES, OUT_WIDTH/(2*BITS), samples per output word (derived, do not override)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
i_tdata  in  32  input sample {I[15:0], Q[15:0]}
i_tlast  in  1  last sample of input packet
i_tvalid  in  1  input valid
i_tready  out  1  input ready
o_tdata  out  OUT_WIDTH  packed word
o_tlast  out  1  word contains last sample of packet
o_tvalid  out  1  output valid
o_tready  in  1  output ready
o_lanes  out  $clog2(LANES+1)  number of occupied lanes in o_tdata (1..LANES)

Behaviour:
- Lane value: {I', Q'}, 2*BITS bits wide.
  - Default: I' = I[15:16-BITS] and Q' = Q[15:16-BITS] (MSB truncation).
- Lane order: the first sample of a word goes in the top lane, o_tdata[OUT_WIDTH-1 -: 2*BITS]. Later samples fill downward.
- Accumulator: a word register plus a lane counter cnt (0..LANES-1).
  - An accepted sample is written into lane cnt; cnt then increments.
- Completing sample: an accepted sample where cnt==LANES-1 or i_tlast==1.
  - On the cycle after it is accepted, the assembled word moves to the output register.
  - Unused lanes are zero.
  - o_lanes = cnt+1.
  - o_tlast = i_tlast of that sample.
  - cnt returns to 0 and the accumulator is cleared.
- Latency: o_tvalid rises 1 cycle after the completing sample is accepted.
- Output register (one entry):
  - o_tvalid is held until o_tready.
  - o_tdata, o_tlast and o_lanes are stable while o_tvalid && !o_tready.
- i_tready:
  - Non-completing samples: always 1.
  - Completing samples: 1 only if the output register is empty or draining this cycle, i.e. i_tready = !completing || !o_tvalid || o_tready.
  - i_tready must not depend combinationally on i_tvalid beyond the completing decode of i_tdata-independent state (cnt==LANES-1). It may depend on i_tlast.
- Simultaneous events:
  - Output handshake and completing-sample acceptance in the same cycle: the output register reloads and o_tvalid stays 1 with no bubble.
  - tlast on the LANES-th sample: one full word with o_tlast=1. No extra empty word.
  - tlast on the first sample: a single-lane word, o_lanes=1.
- Throughput: one input sample per cycle sustained when o_tready=1.
- Reset (also mid-packet):
  - o_tvalid=0, o_tdata=0, o_tlast=0, o_lanes=0.
  - cnt=0, accumulator=0.
  - Partial words are discarded.
  - i_tready=1 in the first cycle after reset.
- Elaboration error if OUT_WIDTH % (2*BITS) != 0, BITS < 1 or BITS > 16.

Optional Feature:
IQ_PACK_ROUND_EN
- Defined: each component is rounded half-up before slicing.
  - Compute c + 2^(15-BITS) in 17-bit signed arithmetic.
  - Saturate to [-2^15, 2^15-1].
  - Take bits [15:16-BITS].
  - With BITS=16 no rounding term is added (identity).
- Not defined: plain truncation, no adder in the path.
- Latency and handshake are identical in both builds.

Test Plan:
1. Full word, BITS=4, OUT_WIDTH=32. Input samples (I,Q) = (0x1000,0x2000), (0x3000,0x4000), (0x5000,0x6000), (0x7000,0x8000), no tlast -> o_tdata=0x12345678, o_lanes=4, o_tlast=0, o_tvalid one cycle after the 4th accept.
2. Partial flush. Same first two samples, tlast on the 2nd -> o_tdata=0x12340000, o_lanes=2, o_tlast=1. The next sample starts a new word in the top lane.
3. Backpressure. o_tready=0, stream 8 samples back-to-back -> first word held stable. Samples 5-7 are accepted; i_tready=0 when the 8th is presented. Raising o_tready for 1 cycle -> 8th accepted that cycle, the second word appears the next cycle with no gap in o_tvalid.
4. Sustained rate. o_tready=1, 64 continuous samples with tlast every 10 -> i_tready constantly 1. Words have lanes 4,4,2 repeating, with o_tlast on each 2-lane word.
5. Reset mid-word. Accept 3 samples, assert reset for 1 cycle -> no output word, o_tvalid=0. The next 4 samples form a clean word.
6. Rounding (IQ_PACK_ROUND_EN).
   - I=0x17FF -> nibble 1.
   - I=0x1800 -> 2.
   - I=0x7C00 -> 7 (saturated).
   - Q=0x8000 -> 8.
   - Without the macro: 0x1800 -> 1 and 0x7C00 -> 7.

Source files
------------

// File: rtl/iq_sample_packer.sv
// -----------------------------------------------------------------------------
// iq_sample_packer
//
// Packs a stream of 32-bit IQ samples ({I[15:0], Q[15:0]}) into OUT_WIDTH-bit
// words. Each component is reduced to BITS bits, which gives a 2*BITS-bit lane
// {I', Q'}. Each word holds LANES lanes. The first sample of a word goes in the
// top lane, and later samples fill downward. When tlast arrives on the input,
// a partial word is flushed early, and its unused lanes are zero. The output
// is a single registered entry that is safe under backpressure.
//
// Optional build macro:
//   IQ_PACK_ROUND_EN : round each component half-up and saturate before
//                      slicing. When undefined, plain MSB truncation is used.
//
// Parameters:
//   OUT_WIDTH : output word width, must be a multiple of 2*BITS
//   BITS      : retained bits per I/Q component, 1..16
//   LANES     : samples per output word (derived, do not override)
//
// Ports:
//   clk, reset : clock; synchronous active-high reset
//   i_tdata    : input sample {I, Q}
//   i_tlast    : last sample of the input packet
//   i_tvalid   : input valid
//   i_tready   : input ready
//   o_tdata    : packed output word
//   o_tlast    : word contains the last sample of a packet
//   o_tvalid   : output valid
//   o_tready   : output ready
//   o_lanes    : number of occupied lanes in o_tdata (1..LANES)
// -----------------------------------------------------------------------------
module iq_sample_packer #(
  parameter int  OUT_WIDTH = 32,
  parameter int  BITS      = 4,
  localparam int LANES     = OUT_WIDTH / (2 * BITS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  i_tdata,
  input  logic                         i_tlast,
  input  logic                         i_tvalid,
  output logic                         i_tready,
  output logic [OUT_WIDTH-1:0]         o_tdata,
  output logic                         o_tlast,
  output logic                         o_tvalid,
  input  logic                         o_tready,
  output logic [$clog2(LANES+1)-1:0]   o_lanes
);

  localparam int LANE_W = 2 * BITS;
  localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int NL_W   = $clog2(LANES + 1);
  localparam bit CFG_OK = (BITS >= 1) && (BITS <= 16) && ((OUT_WIDTH % (2 * BITS)) == 0);

  if (!CFG_OK) begin : g_bad_cfg
    $error("iq_sample_packer: illegal OUT_WIDTH/BITS combination");
  end

  // ---------------------------------------------------------------------------
  // Component reduction
  // ---------------------------------------------------------------------------
  logic [LANE_W-1:0] lane_val;

`ifdef IQ_PACK_ROUND_EN
  localparam int RND_SH = (BITS < 16) ? (15 - BITS) : 0;
  localparam int RND    = (BITS < 16) ? (1 << RND_SH) : 0;

  // Half-up rounding in 17-bit signed arithmetic. The rounding term is
  // positive, so only the positive rail can overflow.
  function automatic logic [BITS-1:0] round_comp(input logic [15:0] c);
    logic signed [16:0] sum;
    logic [15:0]        sat;
    sum = $signed({c[15], c}) + $signed(17'(RND));
    sat = (sum > 17'sd32767) ? 16'h7fff : sum[15:0];
    return sat[15 -: BITS];
  endfunction

  always_comb begin
    lane_val = {round_comp(i_tdata[31:16]), round_comp(i_tdata[15:0])};
  end
`else
  always_comb begin
    lane_val = {i_tdata[31 -: BITS], i_tdata[15 -: BITS]};
  end

  // The low-order bits are dropped by truncation.
  if (BITS < 16) begin : g_unused_low
    logic unused_low_bits;
    assign unused_low_bits = ^{i_tdata[31-BITS:16], i_tdata[15-BITS:0]};
  end
`endif

  // ---------------------------------------------------------------------------
  // Accumulator and handshake
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]     cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_next;
  logic                 completing;
  logic                 accept;

  // A sample completes the word if it fills the bottom lane or ends a packet.
  // This decode uses cnt and i_tlast only, never i_tvalid or i_tdata.
  assign completing = (cnt == CNT_W'(LANES - 1)) || i_tlast;
  assign i_tready   = !completing || !o_tvalid || o_tready;
  assign accept     = i_tvalid && i_tready;

  // NOTE: a combinational block assigns every output before any branch can
  // skip it. Otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    acc_next = acc;
    acc_next = acc | (OUT_WIDTH'(lane_val) << (LANE_W * (LANES - 1 - int'(cnt))));
  end

  // NOTE: sequential state uses non-blocking assignments. Every register then
  // sees the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    // NOTE: the accumulator is reset along with the control registers, so a
    // partial word left over from before the reset cannot leak into the next one.
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_tvalid <= 1'b0;
      o_lanes  <= '0;
    end else if (accept && completing) begin
      // Move the finished word straight into the output register. This
      // reloads without a bubble when the previous word drains this cycle.
      o_tdata  <= acc_next;
      o_tlast  <= i_tlast;
      o_lanes  <= NL_W'(cnt) + NL_W'(1);
      o_tvalid <= 1'b1;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
      end
      if (o_tready) begin
        o_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iq_sample_packer.sv
// -----------------------------------------------------------------------------
// tb_iq_sample_packer
//
// Self-checking bench for iq_sample_packer (OUT_WIDTH=32, BITS=4).
// The stimulus side pushes expected words into a queue as samples are
// accepted. A separate monitor pops from that queue and compares on every
// output handshake. The monitor also checks that the output holds steady
// while stalled. The reference model builds each word from lane lists with
// plain arithmetic. Directed tests push fixed constant words instead.
// -----------------------------------------------------------------------------
module tb_iq_sample_packer;

  localparam int OUT_WIDTH = 32;
  localparam int BITS      = 4;
  localparam int LANES     = OUT_WIDTH / (2 * BITS);
  localparam int NL_W      = $clog2(LANES + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [31:0]          i_tdata;
  logic                 i_tlast;
  logic                 i_tvalid;
  logic                 i_tready;
  logic [OUT_WIDTH-1:0] o_tdata;
  logic                 o_tlast;
  logic                 o_tvalid;
  logic                 o_tready;
  logic [NL_W-1:0]      o_lanes;

  iq_sample_packer #(.OUT_WIDTH(OUT_WIDTH), .BITS(BITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .o_lanes  (o_lanes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_WIDTH-1:0] data;
    int                   lanes;
    logic                 last;
  } exp_t;

  exp_t exp_q[$];
  int   pend[$];
  bit   model_en   = 1'b0;
  bit   rand_ready = 1'b0;
  int   n_cmp      = 0;
  int   n_bad      = 0;
  int   stall_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reduce one 16-bit two's-complement component to BITS bits.
  function automatic int reduce(input logic [15:0] c);
    int v;
    v = $signed(c);
`ifdef IQ_PACK_ROUND_EN
    if (BITS < 16) v = v + (1 << (15 - BITS));
    if (v > 32767) v = 32767;
`endif
    return (v >>> (16 - BITS)) & ((1 << BITS) - 1);
  endfunction

  task automatic push_expect(input logic [OUT_WIDTH-1:0] data, input int lanes, input logic last);
    exp_t e;
    e.data  = data;
    e.lanes = lanes;
    e.last  = last;
    exp_q.push_back(e);
  endtask

  // Reference model: collect lanes and emit a word when it is full or on tlast.
  task automatic model_accept(input logic [15:0] iv, input logic [15:0] qv, input logic last);
    logic [OUT_WIDTH-1:0] w;
    if (!model_en) return;
    pend.push_back((reduce(iv) << BITS) | reduce(qv));
    if (pend.size() == LANES || last) begin
      w = '0;
      for (int k = 0; k < pend.size(); k++)
        w = w | (OUT_WIDTH'(pend[k]) << (OUT_WIDTH - 2 * BITS * (k + 1)));
      push_expect(w, pend.size(), last);
      pend.delete();
    end
  endtask

  // Present one sample and wait until it is accepted. The task is called and
  // returns at posedge+1.
  task automatic send(input logic [15:0] iv, input logic [15:0] qv, input logic last);
    int waited;
    waited   = 0;
    i_tdata  = {iv, qv};
    i_tlast  = last;
    i_tvalid = 1'b1;
    @(negedge clk);
    while (!i_tready && waited < 1000) begin
      waited++;
      stall_cnt++;
      @(negedge clk);
    end
    if (!i_tready) check("accept_timeout", 64'd0, 64'd1);
    else model_accept(iv, qv, last);
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    i_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_comp();
    logic [15:0] edges [6];
    edges = '{16'h7fff, 16'h8000, 16'h7c00, 16'h17ff, 16'h1800, 16'h0000};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return 16'($urandom);
  endfunction

  // Random output backpressure, enabled only in the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) o_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: scoreboard pop on every handshake, plus a stability check while stalled.
  initial begin
    logic                 held;
    logic [OUT_WIDTH-1:0] h_data;
    logic [NL_W-1:0]      h_lanes;
    logic                 h_last;
    exp_t                 e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held) check("hold_stable", {o_tvalid, o_tlast, 27'(o_lanes), o_tdata},
                        {1'b1, h_last, 27'(h_lanes), h_data});
        if (o_tvalid && o_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(o_tdata), 64'hdead_0000_0000_0000);
          end else begin
            e = exp_q.pop_front();
            check("word_data", 64'(o_tdata), 64'(e.data));
            check("word_lanes", 64'(o_lanes), 64'(e.lanes));
            check("word_last", 64'(o_tlast), 64'(e.last));
          end
        end
        held    = o_tvalid && !o_tready;
        h_data  = o_tdata;
        h_lanes = o_lanes;
        h_last  = o_tlast;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain;
    reset    = 1'b1;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_tdata",  64'(o_tdata),  64'd0);
    check("rst_tlast",  64'(o_tlast),  64'd0);
    check("rst_lanes",  64'(o_lanes),  64'd0);
    reset = 1'b0;
    check("rst_iready", 64'(i_tready), 64'd1);

    // 1: full word, one-cycle latency
    o_tready = 1'b1;
    model_en = 1'b0;
    push_expect(32'h1234_5678, 4, 1'b0);
    send(16'h1000, 16'h2000, 1'b0);
    send(16'h3000, 16'h4000, 1'b0);
    send(16'h5000, 16'h6000, 1'b0);
    check("t1_no_early_valid", 64'(o_tvalid), 64'd0);
    send(16'h7000, 16'h8000, 1'b0);
    check("t1_latency", 64'(o_tvalid), 64'd1);
    idle(2);

    // 2: partial flush, then a tlast on the first sample of a new word
    push_expect(32'h1234_0000, 2, 1'b1);
    push_expect(32'h5600_0000, 1, 1'b1);
    send(16'h1000, 16'h2000, 1'b0);
    send(16'h3000, 16'h4000, 1'b1);
    send(16'h5000, 16'h6000, 1'b1);
    idle(3);

    // 3: backpressure; the 8th sample waits for the output register to drain
    o_tready = 1'b0;
    push_expect(32'h1234_5678, 4, 1'b0);
    push_expect(32'h9abc_def0, 4, 1'b0);
    send(16'h1000, 16'h2000, 1'b0);
    send(16'h3000, 16'h4000, 1'b0);
    send(16'h5000, 16'h6000, 1'b0);
    send(16'h7000, 16'h8000, 1'b0);
    send(16'h9000, 16'ha000, 1'b0);
    send(16'hb000, 16'hc000, 1'b0);
    send(16'hd000, 16'he000, 1'b0);
    i_tdata  = 32'hf000_0000;
    i_tvalid = 1'b1;
    @(negedge clk);
    check("t3_ready_low", 64'(i_tready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    o_tready = 1'b1;
    @(negedge clk);
    check("t3_ready_high", 64'(i_tready), 64'd1);
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    o_tready = 1'b0;
    check("t3_no_gap", 64'(o_tvalid), 64'd1);
    idle(2);
    o_tready = 1'b1;
    idle(2);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // 4: sustained rate with tlast every 10 samples
    model_en  = 1'b1;
    stall_cnt = 0;
    for (int i = 0; i < 64; i++) send(rand_comp(), rand_comp(), (i % 10) == 9);
    check("t4_no_stall", 64'(stall_cnt), 64'd0);
    idle(3);
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // 5: reset in the middle of a word discards it
    send(16'h1000, 16'h2000, 1'b0);
    send(16'h3000, 16'h4000, 1'b0);
    send(16'h5000, 16'h6000, 1'b0);
    reset = 1'b1;
    pend.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("t5_tvalid", 64'(o_tvalid), 64'd0);
    check("t5_lanes", 64'(o_lanes), 64'd0);
    idle(2);
    check("t5_still_idle", 64'(o_tvalid), 64'd0);
    for (int i = 0; i < 4; i++) send(rand_comp(), rand_comp(), 1'b0);
    idle(3);
    check("t5_drained", 64'(exp_q.size()), 64'd0);

    // 6: rounding / truncation corner values
    model_en = 1'b0;
`ifdef IQ_PACK_ROUND_EN
    push_expect(32'h1820_7000, 3, 1'b1);
`else
    push_expect(32'h1810_7000, 3, 1'b1);
`endif
    send(16'h17ff, 16'h8000, 1'b0);
    send(16'h1800, 16'h0000, 1'b0);
    send(16'h7c00, 16'h0000, 1'b1);
    idle(3);

    // 7: random traffic with random backpressure
    model_en   = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(rand_comp(), rand_comp(), $urandom_range(0, 7) == 0);
    end
    send(rand_comp(), rand_comp(), 1'b1);
    rand_ready = 1'b0;
    idle(1);
    o_tready = 1'b1;
    drain = 0;
    while (exp_q.size() != 0 && drain < 50) begin
      idle(1);
      drain++;
    end
    idle(2);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
